// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_ADC   = 4'b0010,
    OP_PASSA = 4'b0011,
    OP_PASSB = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_AND   = 4'b0111,
    OP_OR    = 4'b1000,
    OP_SLL   = 4'b1001,
    OP_SRL   = 4'b1010,
    OP_EQ    = 4'b1011,
    OP_LT    = 4'b1100,
    OP_RXOR  = 4'b1101,
    OP_MUL   = 4'b1110,
    OP_RSVD  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Working registers and iteration counter for the one-bit-per-cycle shift and
// shift-add multiply; exposes the post-step value so the final step can be captured.
module alu_iter_unit #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mul_sel,
  input  logic             left_sel,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [CNT_W-1:0] cnt_init,
  input  logic             step,
  output logic             last,
  output logic [W-1:0]     res,
  output logic             sc
);

  logic [2*W-1:0] work;
  logic [2*W-1:0] work_n;
  logic [2*W-1:0] acc_n;
  logic [W-1:0]   mcand;
  logic [CNT_W-1:0] cnt;
  logic           is_mul;
  logic           is_left;
  logic [W:0]     psum;
  logic [W-1:0]   sh_n;
  logic           sh_out;

  always_comb begin
    // Multiplier sits in the low half; each step adds the multiplicand to the
    // high half when the current multiplier bit is set, then shifts right.
    psum   = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, mcand} : '0);
    acc_n  = {psum, work[W-1:1]};
    sh_n   = '0;
    sh_out = 1'b0;
    if (is_left) begin
      {sh_out, sh_n} = {work[W-1:0], 1'b0};
    end else begin
      {sh_n, sh_out} = {1'b0, work[W-1:0]};
    end
    work_n = is_mul ? acc_n : {{W{1'b0}}, sh_n};
    res    = is_mul ? acc_n[W-1:0] : sh_n;
    sc     = is_mul ? (|acc_n[2*W-1:W]) : sh_out;
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work    <= '0;
      mcand   <= '0;
      cnt     <= '0;
      is_mul  <= 1'b0;
      is_left <= 1'b0;
    end else if (load) begin
      is_mul  <= mul_sel;
      is_left <= left_sel;
      cnt     <= cnt_init;
      mcand   <= a;
      work    <= mul_sel ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
    end else if (step) begin
      cnt  <= cnt - CNT_W'(1);
      work <= work_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake; single-cycle ops resolve
// here, shifts and multiply iterate in alu_iter_unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         zero,
  output logic         pari,
  output logic         one
);

  localparam logic [W-1:0]     W_B   = W'(W);
  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

  alu_state_e       state;
  alu_op_e          op;
  logic [CNT_W-1:0] shamt;
  logic [CNT_W-1:0] cnt_init;
  logic             is_shift;
  logic             iter_shift;
  logic             iter_mul;
  logic             it_load;
  logic             it_step;
  logic             it_last;
  logic [W-1:0]     it_res;
  logic             it_sc;
  logic [W:0]       sum;
  logic [W-1:0]     s_res;
  logic             s_sc;

  assign op         = alu_op_e'(alu_cmd);
  assign shamt      = (inB >= W_B) ? W_CNT : inB[CNT_W-1:0];
  assign is_shift   = (op == OP_SLL) || (op == OP_SRL);
  assign iter_shift = is_shift && (shamt != '0);
  assign iter_mul   = (op == OP_MUL);
  assign cnt_init   = iter_mul ? W_CNT : shamt;
  assign it_load    = (state == ST_IDLE) && start && (iter_shift || iter_mul);
  assign it_step    = (state != ST_IDLE);

  always_comb begin
    sum   = '0;
    s_res = '0;
    s_sc  = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, inA} + {1'b0, inB};
        s_res = sum[W-1:0];
        s_sc  = sum[W];
      end
      OP_SUB: begin
        sum   = {1'b0, inA} - {1'b0, inB};
        s_res = sum[W-1:0];
        s_sc  = sum[W];
      end
      OP_ADC: begin
        sum   = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
        s_res = sum[W-1:0];
        s_sc  = sum[W];
      end
      OP_PASSA: s_res = inA;
      OP_PASSB: s_res = inB;
      OP_NOR:   s_res = ~(inA | inB);
      OP_XOR:   s_res = inA ^ inB;
      OP_AND:   s_res = inA & inB;
      OP_OR:    s_res = inA | inB;
      OP_SLL, OP_SRL: s_res = inA;  // only reached for a zero shift amount
      OP_EQ:    s_res = {{(W-1){1'b0}}, (inA == inB)};
      OP_LT:    s_res = {{(W-1){1'b0}}, (inA < inB)};
      OP_RXOR:  s_res = {{(W-1){1'b0}}, ^inB};
      default:  s_res = '0;
    endcase
  end

  alu_iter_unit #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (it_load),
    .mul_sel  (iter_mul),
    .left_sel (op == OP_SLL),
    .a        (inA),
    .b        (inB),
    .cnt_init (cnt_init),
    .step     (it_step),
    .last     (it_last),
    .res      (it_res),
    .sc       (it_sc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rslt  <= '0;
      sc_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (iter_mul) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else if (iter_shift) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              rslt <= s_res;
              sc_o <= s_sc;
              done <= 1'b1;
            end
          end
        end
        ST_SHIFT, ST_MUL: begin
          if (it_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            rslt  <= it_res;
            sc_o  <= it_sc;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign zero = (rslt == '0);
  assign pari = ^rslt;
  assign one  = (rslt == W'(1));

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 8-bit combinational ALU in the X9 datapath. It adds registered results, a start/busy/done handshake, and carry-in arithmetic. It also adds iterative shift and multiply units, so wide datapaths do not need a barrel shifter or array multiplier. It sits between the register file read ports and the writeback mux; the controller stalls issue while `busy` is high.

## Interface

Parameters:
- `W`, default 8: operand and result width; must be ≥ 4.
- `CNT_W`, default `$clog2(W+1)`: width of the iteration counter.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new operation; sampled only while `busy` is 0.
- `alu_cmd`, input, 4: operation code, latched on an accepted `start`.
- `inA`, input, W: operand A, latched on an accepted `start`.
- `inB`, input, W: operand B, latched on an accepted `start`.
- `sc_i`, input, 1: carry in, latched on an accepted `start`.
- `busy`, output, 1: an iterative operation is in progress.
- `done`, output, 1: one-cycle pulse; `rslt` and `sc_o` are updated in this cycle.
- `rslt`, output, W: registered result; held until the next `done`.
- `sc_o`, output, 1: registered carry/borrow/shift-out/overflow bit.
- `zero`, output, 1: `rslt == 0`, combinational from `rslt`.
- `pari`, output, 1: `^rslt`.
- `one`, output, 1: `rslt == 1`; the branch-true flag.

## Operation

Encodings live in `alu_pkg`. `sc_o` is 0 unless stated otherwise.
- 0000 ADD: A+B. `sc_o` = carry out.
- 0001 SUB: A−B. `sc_o` = borrow (1 when A<B, unsigned).
- 0010 ADC: A+B+`sc_i`. `sc_o` = carry out.
- 0011 PASSA: A.
- 0100 PASSB: B.
- 0101 NOR.
- 0110 XOR.
- 0111 AND.
- 1000 OR.
- 1001 SLL and 1010 SRL: iterative logical shift by n = min(B, W), zero fill, one bit per cycle. `sc_o` = the last bit shifted out. When n = 0: result is A and `sc_o` = 0, executed as a single-cycle operation.
- 1011 EQ: result = (A==B), zero-extended to W bits.
- 1100 LT: result = (A<B) unsigned, zero-extended.
- 1101 RXOR: result = ^B, zero-extended.
- 1110 MUL: iterative shift-add over W cycles on a 2W-bit accumulator. Result = low W bits; `sc_o` = OR of the high W bits (overflow).
- 1111 reserved: result 0, `sc_o` 0, single-cycle.

FSM states:
- IDLE: accepts `start`.
  - Single-cycle op: goes to IDLE and writes result.
  - SLL/SRL with n>0: goes to SHIFT with counter = n.
  - MUL: goes to MUL with counter = W.
- SHIFT: shifts the working register one bit per cycle and decrements the counter. At counter = 1, writes the result and returns to IDLE.
- MUL: performs one add-shift step per cycle and decrements the counter. At counter = 1, writes the result and returns to IDLE.

Datapath rules:
- A separate working register is used, so `rslt` never shows intermediate values.
- All arithmetic is performed W+1 bits wide; the top bit becomes `sc_o`.

## Timing

- Reset values: `rslt`=0, `sc_o`=0, `busy`=0, `done`=0, state IDLE. Therefore `zero`=1, `pari`=0, `one`=0.
- `start` accepted in cycle c:
  - Single-cycle op: `done`=1 in cycle c+1.
  - Shift with n≥1: `busy`=1 in cycles c+1 … c+n; `done` in cycle c+n+1.
  - MUL: `busy` in cycles c+1 … c+W; `done` in cycle c+W+1.
- `busy`=0 in the `done` cycle, so a `start` in that cycle is accepted. Back-to-back single-cycle ops sustain one result per cycle.
- `start` while `busy`=1 is ignored, not queued. Operand changes during `busy` have no effect.
- `reset` during SHIFT/MUL aborts immediately. Outputs take their reset values and no `done` is issued.
- Flags change only with `rslt`, i.e. at `done` or reset.

## Structure

- `alu_pkg` holds:
  - the `alu_op_e` enum (4-bit encodings above);
  - the `alu_state_e` enum (IDLE, SHIFT, MUL).
- One sub-module, `alu_iter_unit`, holds the shift/multiply working registers and counter. It takes load/step controls from the top FSM and reports `last`.
- Single-cycle ops, the FSM and the output registers live in `alu_seq`.

## Test plan

1. Assert `reset` with no clock edges: `rslt`=0, `zero`=1, `busy`=0, `done`=0.
2. W=8, ADD 200+100 at cycle c: `rslt`=44, `sc_o`=1, `done` at c+1. Then SUB 5−7 issued at c+1: `rslt`=254, `sc_o`=1, `done` at c+2.
3. SLL A=8'b1000_0001, B=3: `busy` for 3 cycles, `done` at c+4, `rslt`=8'b0000_1000, `sc_o`=0. SRL A=8'hFF, B=9: n=8, `done` at c+9, `rslt`=0, `zero`=1, `sc_o`=1.
4. MUL 15×17: `done` at c+9, `rslt`=255, `sc_o`=0. MUL 16×16: `rslt`=0, `sc_o`=1, `zero`=1. Pulse `start` with ADD during `busy`: ignored, exactly one `done` is produced.
5. Start MUL at c and assert `reset` at c+4: `busy`→0 immediately, `rslt`=0, no `done` pulse.
6. ADC 255+0 with `sc_i`=1: `rslt`=0, `sc_o`=1. EQ 7==7: `rslt`=1, `one`=1, `pari`=1. Opcode 1111: `rslt`=0, `done` at c+1.
